// File: rtl/t_chain_counter_if.sv
// Control/status bundle for t_chain_counter; master drives count controls, slave is the counter.
interface t_chain_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] toggle;
    logic             tc;

    // No handshake: inputs are sampled on every rising clk edge; q/tc are registered, toggle is combinational.
    modport master (output en, up, load, din, input q, toggle, tc);
    modport slave  (input en, up, load, din, output q, toggle, tc);
endinterface

// File: rtl/t_chain_counter.sv
// Modulo-MOD up/down counter as a bank of T flip-flops with per-bit toggle chain and registered tc.
// Optional macro TCNT_SATURATE_EN: hold at the count bound instead of wrapping.
module t_chain_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    t_chain_counter_if.slave   cnt_io
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] toggle_d;
    logic [WIDTH-1:0] load_val;
    logic             tc_q;
    logic             tc_d;
    logic             carry;
    logic             at_bound;

    always_comb begin
        toggle_d = '0;
        tc_d     = 1'b0;
        carry    = 1'b1;
        at_bound = 1'b0;
        load_val = (cnt_io.din > MAX_C) ? MAX_C : cnt_io.din;
        if (cnt_io.load) begin
            toggle_d = q_q ^ load_val;
        end else if (cnt_io.en) begin
            at_bound = cnt_io.up ? (q_q == MAX_C) : (q_q == '0);
            // Ripple chain: bit i flips when all lower bits are 1 (up) or 0 (down).
            for (int i = 0; i < WIDTH; i++) begin
                toggle_d[i] = carry;
                carry       = carry & (cnt_io.up ? q_q[i] : ~q_q[i]);
            end
            if (at_bound) begin
`ifdef TCNT_SATURATE_EN
                toggle_d = '0;
`else
                toggle_d = cnt_io.up ? q_q : (q_q ^ MAX_C);
`endif
                tc_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_q ^ toggle_d;
            tc_q <= tc_d;
        end
    end

    assign cnt_io.q      = q_q;
    assign cnt_io.toggle = toggle_d;
    assign cnt_io.tc     = tc_q;

endmodule

// File: tb/tb_t_chain_counter.sv
// Randomized scoreboard bench for t_chain_counter against an arithmetic modulo reference model.
module tb_t_chain_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic clk;
    logic rst_n;

    t_chain_counter_if #(.WIDTH(W)) cnt_if ();

    t_chain_counter #(.WIDTH(W), .MOD(MOD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .cnt_io (cnt_if.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [W:0]   exp_q[$];   // {tc, q} expected after each edge
    logic [W-1:0] tog_q[$];   // toggle expected while inputs are held
    int model_q = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs and record what the spec says must follow
    task automatic drive(input bit e, input bit u, input bit l, input int d);
        int nq;
        bit ntc;
        @(negedge clk);
        cnt_if.en   = e;
        cnt_if.up   = u;
        cnt_if.load = l;
        cnt_if.din  = W'(d);
        ntc = 1'b0;
        if (l) begin
            nq = (d > MOD - 1) ? MOD - 1 : d;
        end else if (e) begin
            if (u) begin
                ntc = (model_q == MOD - 1);
`ifdef TCNT_SATURATE_EN
                nq = ntc ? model_q : model_q + 1;
`else
                nq = (model_q + 1) % MOD;
`endif
            end else begin
                ntc = (model_q == 0);
`ifdef TCNT_SATURATE_EN
                nq = ntc ? model_q : model_q - 1;
`else
                nq = (model_q + MOD - 1) % MOD;
`endif
            end
        end else begin
            nq = model_q;
        end
        tog_q.push_back(W'(model_q ^ nq));
        exp_q.push_back({ntc, W'(nq)});
        model_q = nq;
    endtask

    // monitors
    always @(negedge clk) begin
        #2;
        if (rst_n && tog_q.size() > 0) check("toggle", cnt_if.toggle, tog_q.pop_front());
    end

    always @(posedge clk) begin
        logic [W:0] e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q", cnt_if.q, e[W-1:0]);
            check("tc", cnt_if.tc, e[W]);
        end
    end

    initial begin
        int budget;
        cnt_if.en = 0; cnt_if.up = 0; cnt_if.load = 0; cnt_if.din = '0;
        rst_n = 0;
        #3;
        check("reset_q", cnt_if.q, 0);
        check("reset_tc", cnt_if.tc, 0);
        #7 rst_n = 1;

        repeat (12) drive(1, 1, 0, 0);
        drive(0, 0, 1, 2);
        repeat (4) drive(1, 0, 0, 0);
        drive(1, 1, 1, 13);
        drive(0, 0, 0, 0);

        // async reset mid-count at q=6
        drive(0, 0, 1, 6);
        drive(0, 1, 0, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async_q", cnt_if.q, 0);
        check("async_tc", cnt_if.tc, 0);
        model_q = 0;
        #1 rst_n = 1;
        drive(1, 1, 0, 0);

        drive(0, 0, 1, 4);
        drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);

`ifdef TCNT_SATURATE_EN
        drive(0, 0, 1, 8);
        repeat (4) drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
`endif

        repeat (300) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, (1 << W) - 1));
        end
        drive(0, 0, 0, 0);

        budget = 10;
        while ((exp_q.size() > 0 || tog_q.size() > 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #3;
        if (exp_q.size() > 0 || tog_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", exp_q.size(), tog_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
